ac2_drain: RTL

//  Read-side companion of the ac2 four-bank accumulator. On a capture strobe it

---
 rtl/ac2_drain.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ac2_drain.sv
// rtl/ac2_drain.sv - capture/drain buffer between the ac2 accumulator and the result collector
//
// Purpose:
//   When cap is high, the four ac2 bank results are snapshotted into a holding
//   buffer and a one-cycle clear request is sent back to ac2. The buffer is then
//   streamed out one word per valid/ready handshake. REV selects the bank order.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   cap         in   1   capture strobe (bank results final this cycle)
//   in_ac2_0..3 in   W   bank results, two's complement
//   out_ready   in   1   downstream accepts out_data this cycle
//   clr_err     in   1   clears ovf_err
//   out_valid   out  1   out_data/out_idx/out_last valid
//   out_data    out  W   current buffered word
//   out_idx     out  2   bank index of out_data
//   out_last    out  1   high with the fourth word of a burst
//   cl_req      out  1   one-cycle clear pulse to ac2 after an accepted capture
//   busy        out  1   burst in progress
//   ovf_err     out  1   sticky: a capture was dropped while busy
module ac2_drain #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int REV = 0,
  localparam int W  = $clog2(M) + Pa + Pw + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] in_ac2_0,
  input  logic [W-1:0] in_ac2_1,
  input  logic [W-1:0] in_ac2_2,
  input  logic [W-1:0] in_ac2_3,
  input  logic         out_ready,
  input  logic         clr_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         cl_req,
  output logic         busy,
  output logic         ovf_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [W-1:0] r_buf [4];
  logic [1:0]   r_cnt;
  logic         r_cl_req;
  logic         r_ovf_err;

  logic         w_xfer;    // handshake completes at this edge
  logic         w_accept;  // capture loads the buffer at this edge
  logic         w_drop;    // capture arrives while the buffer is still in use
  logic         w_send;
  logic [1:0]   w_bank;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode. A capture in SEND is only accepted on the
  // final transfer of the burst, which gives zero-bubble back-to-back bursts.
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cap) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_xfer = out_ready;
        if (out_ready && (r_cnt == 2'd3)) begin
          if (cap) begin
            w_accept    = 1'b1;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (cap) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding buffer and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= '0;
      end
      r_cnt <= 2'd0;
    end else begin
      if (w_accept) begin
        r_buf[0] <= in_ac2_0;
        r_buf[1] <= in_ac2_1;
        r_buf[2] <= in_ac2_2;
        r_buf[3] <= in_ac2_3;
        r_cnt    <= 2'd0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // Clear pulse and sticky overflow flag. A drop in the same cycle as clr_err
  // wins so that no lost capture goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cl_req  <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_cl_req <= w_accept;
      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end else if (clr_err) begin
        r_ovf_err <= 1'b0;
      end
    end
  end

  // All outputs derive from state, counter and buffer registers only.
  assign w_send    = (r_state == S_SEND);
  assign w_bank    = (REV != 0) ? (2'd3 - r_cnt) : r_cnt;

  assign out_valid = w_send;
  assign busy      = w_send;
  assign out_data  = w_send ? r_buf[w_bank] : '0;
  assign out_idx   = w_send ? w_bank : 2'd0;
  assign out_last  = w_send && (r_cnt == 2'd3);
  assign cl_req    = r_cl_req;
  assign ovf_err   = r_ovf_err;

endmodule
